// File: rtl/sub_array_stream_packer.sv
// Collects a raster-order element stream into one frame-wide register, reordered so the
// leading SUB_ROWS rows and the remaining rows each form a column-major sub-array.
module sub_array_stream_packer #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SUB_ROWS  = 4
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BIT_WIDTH-1:0]          in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [ROWS*COLS*BIT_WIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_err
);
  localparam int N  = ROWS*COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [IW-1:0] slot;
  logic          xfer, row_end, at_final;

  assign xfer     = in_valid & in_ready;
  assign row_end  = (col == CW'(COLS-1));
  assign at_final = row_end && (row == RW'(ROWS-1));

  // Destination element slot for the current (row, col) position.
  generate
    if (SUB_ROWS == ROWS) begin : g_single
      assign slot = IW'(int'(col)*SUB_ROWS + int'(row));
    end else begin : g_split
      always_comb begin
        if (int'(row) < SUB_ROWS)
          slot = IW'(int'(col)*SUB_ROWS + int'(row));
        else
          slot = IW'(COLS*SUB_ROWS + int'(col)*(ROWS-SUB_ROWS) + int'(row) - SUB_ROWS);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // A consumed frame returns to FILL unless the element accepted in the same cycle completes
  // another frame (only possible when a frame is a single element).
  always_comb begin
    state_nxt = state;
    if (state == FULL && out_ready) state_nxt = FILL;
    if (xfer && at_final)           state_nxt = FULL;
  end

  always_comb begin
    out_valid = (state == FULL);
    in_ready  = (state == FILL) | out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= xfer & (at_final ? ~in_last : in_last);
      if (xfer) begin
        if (at_final || in_last) begin
          row <= '0;
          col <= '0;
        end else if (row_end) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Unwritten slots keep the previous frame's contents; only meaningful while out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    out_data <= '0;
    else if (xfer) out_data[int'(slot)*BIT_WIDTH +: BIT_WIDTH] <= in_data;
  end
endmodule

// File: tb/tb_sub_array_stream_packer.sv
// Randomized bench for sub_array_stream_packer: frame-level reference model feeds a
// scoreboard queue; a negedge monitor checks handshakes, error pulses and packed frames.
module tb_sub_array_stream_packer;
  localparam int BW = 4, ROWS = 8, COLS = 8, SUBR = 4;
  localparam int N = ROWS*COLS;
  localparam int W = N*BW;

  logic          clk = 1'b0, rst_n;
  logic [BW-1:0] in_data;
  logic          in_valid, in_last, in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid, out_ready, frame_err;

  logic [7:0]    d2_in_data;
  logic          d2_in_valid, d2_in_last, d2_in_ready;
  logic [47:0]   d2_out_data;
  logic          d2_out_valid, d2_out_ready, d2_frame_err;

  int passed = 0, total = 0;
  bit rnd_ordy = 1'b0;

  bit           m_full, m_err;
  int           m_k;
  logic [W-1:0] m_mem;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  sub_array_stream_packer #(.BIT_WIDTH(BW), .ROWS(ROWS), .COLS(COLS), .SUB_ROWS(SUBR)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err));

  sub_array_stream_packer #(.BIT_WIDTH(8), .ROWS(2), .COLS(3), .SUB_ROWS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2_in_data), .in_valid(d2_in_valid), .in_last(d2_in_last),
    .in_ready(d2_in_ready), .out_data(d2_out_data), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .frame_err(d2_frame_err));

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: element index k within the frame, raster to sub-array slot by formula.
  always @(posedge clk or negedge rst_n) begin : model
    int r, c, slot;
    bit xfer;
    if (!rst_n) begin
      m_full = 1'b0; m_err = 1'b0; m_k = 0; m_mem = '0;
      exp_q.delete();
    end else begin
      m_err = 1'b0;
      xfer  = in_valid && (!m_full || out_ready);
      if (m_full && out_ready) m_full = 1'b0;
      if (xfer) begin
        r = m_k / COLS;
        c = m_k % COLS;
        slot = (r < SUBR) ? c*SUBR + r : COLS*SUBR + c*(ROWS-SUBR) + (r-SUBR);
        m_mem[slot*BW +: BW] = in_data;
        if (m_k == N-1) begin
          m_full = 1'b1; m_k = 0; m_err = !in_last;
          exp_q.push_back(m_mem);
        end else if (in_last) begin
          m_k = 0; m_err = 1'b1;
        end else begin
          m_k++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", out_valid, m_full);
      chk("in_ready", in_ready, !m_full || out_ready);
      chk("frame_err", frame_err, m_err);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_frame", out_valid, 0);
        else begin
          chk("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ordy) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [BW-1:0] d, input bit last, output int n);
    bit acc;
    n = 0;
    in_data = d; in_last = last; in_valid = 1'b1;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 500);
    if (!acc) chk("send_timeout", acc, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // mode 0: k mod 16 data, otherwise random. Sends positions start..stop-1.
  task automatic send_frame(input int mode, input int start, input int stop, input int err_at,
                            input bit drop_last, input int gap_pct);
    logic [BW-1:0] d;
    int n;
    for (int k = start; k < stop; k++) begin
      d = (mode == 0) ? BW'(k % 16) : BW'($urandom);
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) tick($urandom_range(1, 3));
      send(d, (k == N-1 && !drop_last) || k == err_at, n);
      if (k == err_at) return;
    end
  endtask

  task automatic drain();
    int n = 0;
    rnd_ordy = 1'b0; out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin tick(1); n++; end
    chk("drain", exp_q.size(), 0);
    tick(1);
  endtask

  initial begin
    int n, err_at;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    d2_in_data = '0; d2_in_valid = 1'b0; d2_in_last = 1'b0; d2_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_err", frame_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    tick(1);

    // k mod 16 frame, out_valid one cycle after the last element
    send_frame(0, 0, N, -1, 1'b0, 0);
    @(negedge clk);
    chk("a_valid", out_valid, 1);
    chk("a_elem_1_0", out_data[7:4], 8);
    chk("a_slot32", out_data[32*BW +: BW], 0);
    chk("a_slot41", out_data[41*BW +: BW], 10);
    tick(1);

    // held frame for 10 cycles, then next frame's first element accepted in the handshake cycle
    send_frame(0, 0, N, -1, 1'b0, 0);
    out_ready = 1'b0;
    tick(10);
    out_ready = 1'b1;
    send(BW'($urandom), 1'b0, n);
    chk("accept_in_full", n, 1);
    send_frame(1, 1, N, -1, 1'b0, 0);

    // early last at k=20, then a clean frame
    send_frame(1, 0, N, 20, 1'b0, 0);
    send_frame(0, 0, N, -1, 1'b0, 0);
    // missing last on the final element
    send_frame(1, 0, N, -1, 1'b1, 0);
    drain();

    rnd_ordy = 1'b1;
    repeat (5) begin
      err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N-2)) : -1;
      send_frame(1, 0, N, err_at, $urandom_range(0, 3) == 0, 30);
    end
    drain();

    // reset mid-frame after k=30
    send_frame(1, 0, 31, -1, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send_frame(1, 0, N, -1, 1'b0, 0);
    drain();

    // full-height sub-array: plain column-major order
    for (int i = 1; i <= 6; i++) begin
      d2_in_data = 8'(i); d2_in_valid = 1'b1; d2_in_last = (i == 6);
      tick(1);
    end
    d2_in_valid = 1'b0; d2_in_last = 1'b0;
    @(negedge clk);
    chk("d2_valid", d2_out_valid, 1);
    chk("d2_data", d2_out_data, 48'h060305020401);
    chk("d2_err", d2_frame_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
